// File: rtl/terminal_write_arbiter_pkg.sv
// Shared terminal definitions: screen geometry and the write-arbiter FSM
// encoding. The debugger imports this package too, so geometry changes live here.
package terminal_write_arbiter_pkg;

  localparam int unsigned TERMINAL_COLUMN_SIZE = 80;
  localparam int unsigned TERMINAL_ROW_SIZE    = 30;

  // Last addressable cell of the linear terminal buffer (80x30 -> 2399).
  localparam int unsigned TERMINAL_ADDRESS_MAX =
    TERMINAL_COLUMN_SIZE * TERMINAL_ROW_SIZE - 1;

  // Write-arbiter FSM encoding.
  localparam logic [0:0] STATE_RUN   = 1'b0;
  localparam logic [0:0] STATE_CLEAR = 1'b1;

endpackage

// File: rtl/terminal_write_arbiter_rr.sv
// Two-way round-robin arbiter. A lone valid requester always wins. On a tie,
// the requester that did not win the last completed handshake wins.
module round_robin_arbiter2 (
  input  logic clock,
  input  logic resetN,
  input  logic req0Valid,
  input  logic req1Valid,
  input  logic grantEnable,
  output logic req0Ready,
  output logic req1Ready
);

  // 0 or 1: the requester that completed the most recent handshake.
  logic lastGrant;
  logic grant0;
  logic grant1;

  // A grant only goes to a valid requester, so ready implies valid.
  assign grant0    = req0Valid && (!req1Valid || lastGrant);
  assign grant1    = req1Valid && (!req0Valid || !lastGrant);
  assign req0Ready = grantEnable && grant0;
  assign req1Ready = grantEnable && grant1;

  // Remember the winner, but only when its handshake actually completes.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      lastGrant <= 1'b1;
    end else if (req0Valid && req0Ready) begin
      lastGrant <= 1'b0;
    end else if (req1Valid && req1Ready) begin
      lastGrant <= 1'b1;
    end
  end

endmodule

// File: rtl/terminal_write_arbiter.sv
// Terminal buffer write arbiter: merges debugger-scan and console writes into
// one registered write port, and can sweep the whole screen with CLEAR_CHAR.
module terminal_write_arbiter #(
  parameter int unsigned TERMINAL_ADDRESS_MAX = terminal_write_arbiter_pkg::TERMINAL_ADDRESS_MAX,
  parameter logic [7:0]  CLEAR_CHAR           = 8'h20
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        req0Valid,
  input  logic [11:0] req0Address,
  input  logic [7:0]  req0Data,
  output logic        req0Ready,
  input  logic        req1Valid,
  input  logic [11:0] req1Address,
  input  logic [7:0]  req1Data,
  output logic        req1Ready,
  input  logic        clearRequest,
  output logic        clearBusy,
  output logic        rangeError,
  output logic [11:0] terminalAddress,
  output logic        shouldWriteTerminal,
  output logic [7:0]  terminalWriteData
);

  import terminal_write_arbiter_pkg::STATE_RUN;
  import terminal_write_arbiter_pkg::STATE_CLEAR;

  localparam logic [11:0] LastCell = 12'(TERMINAL_ADDRESS_MAX);

  logic [0:0]  state;
  logic [0:0]  stateNext;
  logic [11:0] clearCount;
  logic [11:0] clearCountNext;
  logic        grantEnable;
  logic        handshake;
  logic        clearStart;
  logic        clearLast;
  logic [11:0] acceptAddress;
  logic [7:0]  acceptData;
  logic        acceptInRange;

  // A clear request pre-empts arbitration in the same cycle it arrives.
  assign grantEnable = (state == STATE_RUN) && !clearRequest;

  round_robin_arbiter2 arbiter (
    .clock       (clock),
    .resetN      (resetN),
    .req0Valid   (req0Valid),
    .req1Valid   (req1Valid),
    .grantEnable (grantEnable),
    .req0Ready   (req0Ready),
    .req1Ready   (req1Ready)
  );

  assign handshake     = (req0Valid && req0Ready) || (req1Valid && req1Ready);
  assign acceptAddress = req0Ready ? req0Address : req1Address;
  assign acceptData    = req0Ready ? req0Data    : req1Data;
  assign acceptInRange = acceptAddress <= LastCell;

  assign clearBusy  = (state == STATE_CLEAR);
  assign clearStart = (state == STATE_RUN) && clearRequest;
  assign clearLast  = (state == STATE_CLEAR) && (clearCount == LastCell);

  // Next state and clear counter. The counter tracks the address currently
  // on the output port, so leaving CLEAR on LastCell keeps it in range.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext      = state;
    clearCountNext = clearCount;
    case (state)
      STATE_RUN: begin
        if (clearRequest) begin
          stateNext      = STATE_CLEAR;
          clearCountNext = '0;
        end
      end
      STATE_CLEAR: begin
        if (clearLast) begin
          stateNext      = STATE_RUN;
          clearCountNext = '0;
        end else begin
          clearCountNext = clearCount + 12'd1;
        end
      end
      default: begin
        stateNext      = STATE_RUN;
        clearCountNext = '0;
      end
    endcase
  end

  // FSM state and clear counter registers; clearRequest in CLEAR is ignored.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= STATE_RUN;
      clearCount <= '0;
    end else begin
      state      <= stateNext;
      clearCount <= clearCountNext;
    end
  end

  // Registered write port. Clear writes go out in lock-step with clearBusy.
  // An out-of-range request keeps the previous address/data on the bus.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      shouldWriteTerminal <= 1'b0;
      terminalAddress     <= '0;
      terminalWriteData   <= '0;
    end else if (clearStart || (state == STATE_CLEAR && !clearLast)) begin
      shouldWriteTerminal <= 1'b1;
      terminalAddress     <= clearCountNext;
      terminalWriteData   <= CLEAR_CHAR;
    end else if (handshake && acceptInRange) begin
      shouldWriteTerminal <= 1'b1;
      terminalAddress     <= acceptAddress;
      terminalWriteData   <= acceptData;
    end else begin
      shouldWriteTerminal <= 1'b0;
    end
  end

  // Sticky flag for any accepted write that had to be dropped.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rangeError <= 1'b0;
    end else if (handshake && !acceptInRange) begin
      rangeError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_terminal_write_arbiter.sv
// Directed bench for terminal_write_arbiter: single write, round-robin tie,
// out-of-range drop, full clear, ignored re-clear and reset mid-clear.
module tb_terminal_write_arbiter;

  logic        clock = 1'b0;
  logic        resetN;
  logic        req0Valid;
  logic [11:0] req0Address;
  logic [7:0]  req0Data;
  logic        req0Ready;
  logic        req1Valid;
  logic [11:0] req1Address;
  logic [7:0]  req1Data;
  logic        req1Ready;
  logic        clearRequest;
  logic        clearBusy;
  logic        rangeError;
  logic [11:0] terminalAddress;
  logic        shouldWriteTerminal;
  logic [7:0]  terminalWriteData;

  int checks = 0;
  int errors = 0;

  terminal_write_arbiter dut (
    .clock               (clock),
    .resetN              (resetN),
    .req0Valid           (req0Valid),
    .req0Address         (req0Address),
    .req0Data            (req0Data),
    .req0Ready           (req0Ready),
    .req1Valid           (req1Valid),
    .req1Address         (req1Address),
    .req1Data            (req1Data),
    .req1Ready           (req1Ready),
    .clearRequest        (clearRequest),
    .clearBusy           (clearBusy),
    .rangeError          (rangeError),
    .terminalAddress     (terminalAddress),
    .shouldWriteTerminal (shouldWriteTerminal),
    .terminalWriteData   (terminalWriteData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    #3;
    check("reset_write", 32'(shouldWriteTerminal), 32'd0);
    check("reset_addr", 32'(terminalAddress), 32'd0);
    check("reset_data", 32'(terminalWriteData), 32'd0);
    check("reset_busy", 32'(clearBusy), 32'd0);
    check("reset_range", 32'(rangeError), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    tick();
  endtask

  // Follow a clear sweep. Expects address k on cycle k with CLEAR_CHAR and no
  // ready. Pulses clearRequest at pulseAt; stops early when k reaches stopAt.
  task automatic watchClear(input int pulseAt, input int stopAt, output int cycles, output int bad);
    int k;
    k   = 0;
    bad = 0;
    while (clearBusy && k < 3000 && k != stopAt) begin
      if (!(shouldWriteTerminal && terminalAddress == 12'(k) &&
            terminalWriteData == 8'h20 && !req0Ready && !req1Ready))
        bad++;
      clearRequest = (k == pulseAt);
      tick();
      clearRequest = 1'b0;
      k++;
    end
    cycles = k;
  endtask

  initial begin
    int cycles;
    int bad;
    int spurious;
    logic expectGrant1;

    req0Valid = 0; req0Address = '0; req0Data = '0;
    req1Valid = 0; req1Address = '0; req1Data = '0;
    clearRequest = 0;

    // Single write from requester 0.
    applyReset();
    req0Valid = 1; req0Address = 12'd5; req0Data = 8'h41;
    #1;
    check("t1_ready0", 32'(req0Ready), 32'd1);
    check("t1_ready1", 32'(req1Ready), 32'd0);
    tick();
    req0Valid = 0;
    check("t1_write", 32'(shouldWriteTerminal), 32'd1);
    check("t1_addr", 32'(terminalAddress), 32'd5);
    check("t1_data", 32'(terminalWriteData), 32'h41);
    tick();
    check("t1_idle_write", 32'(shouldWriteTerminal), 32'd0);
    check("t1_hold_addr", 32'(terminalAddress), 32'd5);
    check("t1_hold_data", 32'(terminalWriteData), 32'h41);

    // Tie after reset: grants alternate 0,1,0,1 with back-to-back writes.
    applyReset();
    for (int i = 0; i < 4; i++) begin
      expectGrant1 = (i % 2) == 1;
      req0Valid = 1; req0Address = 12'(100 + i); req0Data = 8'(8'h61 + i);
      req1Valid = 1; req1Address = 12'(200 + i); req1Data = 8'(8'h71 + i);
      #1;
      check($sformatf("t2_ready0_%0d", i), 32'(req0Ready), 32'(!expectGrant1));
      check($sformatf("t2_ready1_%0d", i), 32'(req1Ready), 32'(expectGrant1));
      tick();
      check($sformatf("t2_write_%0d", i), 32'(shouldWriteTerminal), 32'd1);
      check($sformatf("t2_addr_%0d", i), 32'(terminalAddress),
            expectGrant1 ? 32'(200 + i) : 32'(100 + i));
      check($sformatf("t2_data_%0d", i), 32'(terminalWriteData),
            expectGrant1 ? 32'(8'h71 + i) : 32'(8'h61 + i));
    end
    req0Valid = 0; req1Valid = 0;

    // Out-of-range write: accepted, dropped, sticky error.
    req0Valid = 1; req0Address = 12'd2400; req0Data = 8'h58;
    #1;
    check("t3_ready0", 32'(req0Ready), 32'd1);
    tick();
    req0Valid = 0;
    check("t3_write", 32'(shouldWriteTerminal), 32'd0);
    check("t3_range", 32'(rangeError), 32'd1);
    repeat (5) tick();
    check("t3_range_sticky", 32'(rangeError), 32'd1);

    // Clear beats a simultaneous console write; console wins right after.
    req1Valid = 1; req1Address = 12'd300; req1Data = 8'h63;
    clearRequest = 1;
    #1;
    check("t4_ready1_blocked", 32'(req1Ready), 32'd0);
    tick();
    clearRequest = 0;
    check("t4_busy", 32'(clearBusy), 32'd1);
    watchClear(-1, -1, cycles, bad);
    check("t4_clear_cycles", 32'(cycles), 32'd2400);
    check("t4_clear_bad", 32'(bad), 32'd0);
    check("t4_busy_done", 32'(clearBusy), 32'd0);
    check("t4_ready1_resume", 32'(req1Ready), 32'd1);
    tick();
    req1Valid = 0;
    check("t4_write", 32'(shouldWriteTerminal), 32'd1);
    check("t4_addr", 32'(terminalAddress), 32'd300);
    check("t4_data", 32'(terminalWriteData), 32'h63);

    // A second clearRequest during the sweep changes nothing.
    clearRequest = 1;
    tick();
    clearRequest = 0;
    watchClear(10, -1, cycles, bad);
    check("t5_clear_cycles", 32'(cycles), 32'd2400);
    check("t5_clear_bad", 32'(bad), 32'd0);
    check("t5_busy_done", 32'(clearBusy), 32'd0);

    // Reset in the middle of a sweep aborts it for good.
    clearRequest = 1;
    tick();
    clearRequest = 0;
    watchClear(-1, 1000, cycles, bad);
    check("t6_reached", 32'(cycles), 32'd1000);
    check("t6_addr_before", 32'(terminalAddress), 32'd1000);
    resetN = 1'b0;
    #1;
    check("t6_rst_write", 32'(shouldWriteTerminal), 32'd0);
    check("t6_rst_addr", 32'(terminalAddress), 32'd0);
    check("t6_rst_data", 32'(terminalWriteData), 32'd0);
    check("t6_rst_busy", 32'(clearBusy), 32'd0);
    check("t6_rst_range", 32'(rangeError), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    spurious = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (clearBusy || (shouldWriteTerminal && terminalWriteData == 8'h20))
        spurious++;
    end
    check("t6_no_clear_after", 32'(spurious), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
